wb_commit_unit: RTL and testbench

Parametrised write-back/commit stage for the RISC-V pipeline. Accepts one MEM/WB entry per cycle over a valid/ready handshake. Selects the result among ALU, load, PC+4 and CSR sources, and aligns and extends sub-word load data. Stalls on late memory responses, then drives a registered register-file write port that doubles as the last forwarding source.

---
 rtl/wb_commit_unit.sv | 203 ++++++++++++++++++++
 tb/tb_wb_commit_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: picks the result source, aligns/extends load data, and waits out late memory responses.
// Optional retire counter is enabled with the WB_RETIRE_CNT_EN macro.
module wb_commit_unit #(
    parameter int  XLEN       = 32,
    parameter int  REG_ADDR_W = 5,
    localparam int OFF_W      = $clog2(XLEN / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_load_type,
    input  logic [OFF_W-1:0]      in_addr_lo,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       in_csr_data,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  load_fault,
    output logic                  busy
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           retire_count
`endif
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    cap_rw_q, cap_rw_d;
    logic [REG_ADDR_W-1:0]   cap_rd_q, cap_rd_d;
    logic [2:0]              cap_type_q, cap_type_d;
    logic [OFF_W-1:0]        cap_off_q, cap_off_d;

    logic                    accept_s, commit_s, pending_s, is_load_s, fault_s;
    logic                    c_rw_s;
    logic [REG_ADDR_W-1:0]   c_rd_s;
    logic [2:0]              c_type_s;
    logic [OFF_W-1:0]        c_off_s;
    logic [XLEN-1:0]         result_s;

    logic                    rf_we_q, load_fault_q;
    logic [REG_ADDR_W-1:0]   rf_waddr_q;
    logic [XLEN-1:0]         rf_wdata_q;

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0] ltype,
                                                     input logic [OFF_W-1:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = word >> {off, 3'b000};
        case (ltype)
            3'b000:  res = XLEN'($signed(sh[7:0]));
            3'b001:  res = XLEN'($signed(sh[15:0]));
            3'b010:  res = XLEN'($signed(sh[31:0]));
            3'b011:  res = sh;
            3'b100:  res = XLEN'(sh[7:0]);
            3'b101:  res = XLEN'(sh[15:0]);
            3'b110:  res = XLEN'(sh[31:0]);
            default: res = '0;
        endcase
        load_extract = res;
    endfunction

    // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
    function automatic logic load_bad(input logic [2:0] ltype, input logic [OFF_W-1:0] off);
        logic bad;
        case (ltype)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off[1:0] != 2'b00);
            3'b110:         bad = (XLEN == 32) || (off[1:0] != 2'b00);
            3'b011:         bad = (XLEN == 32) || (off != '0);
            default:        bad = 1'b1;
        endcase
        load_bad = bad;
    endfunction

    assign accept_s  = in_valid && (state_q == S_IDLE);
    assign pending_s = (state_q == S_WAIT_MEM);
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = pending_s;

    // Next-state logic: decides when an entry commits and when a load must wait.
    always_comb begin
        state_d    = state_q;
        cap_rw_d   = cap_rw_q;
        cap_rd_d   = cap_rd_q;
        cap_type_d = cap_type_q;
        cap_off_d  = cap_off_q;
        commit_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if ((in_wb_sel != 2'b01) || mem_rsp_valid) begin
                        commit_s = 1'b1;
                    end else begin
                        cap_rw_d   = in_reg_write;
                        cap_rd_d   = in_rd;
                        cap_type_d = in_load_type;
                        cap_off_d  = in_addr_lo;
                        state_d    = S_WAIT_MEM;
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    commit_s = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT_MEM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Commit fields come from the capture registers when finishing a deferred load.
    always_comb begin
        c_rw_s    = pending_s ? cap_rw_q   : in_reg_write;
        c_rd_s    = pending_s ? cap_rd_q   : in_rd;
        c_type_s  = pending_s ? cap_type_q : in_load_type;
        c_off_s   = pending_s ? cap_off_q  : in_addr_lo;
        is_load_s = pending_s || (in_wb_sel == 2'b01);
        fault_s   = is_load_s && load_bad(c_type_s, c_off_s);
        if (is_load_s) begin
            result_s = load_extract(mem_rsp_data, c_type_s, c_off_s);
        end else begin
            case (in_wb_sel)
                2'b00:   result_s = in_alu_result;
                2'b10:   result_s = in_pc_plus4;
                2'b11:   result_s = in_csr_data;
                default: result_s = '0;
            endcase
        end
    end

    // State and deferred-load capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cap_rw_q   <= 1'b0;
            cap_rd_q   <= '0;
            cap_type_q <= 3'b000;
            cap_off_q  <= '0;
        end else begin
            state_q    <= state_d;
            cap_rw_q   <= cap_rw_d;
            cap_rd_q   <= cap_rd_d;
            cap_type_q <= cap_type_d;
            cap_off_q  <= cap_off_d;
        end
    end

    // Registered write port; also the last forwarding source for earlier stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            load_fault_q <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            rf_we_q      <= commit_s && c_rw_s && (c_rd_s != '0) && !fault_s;
            load_fault_q <= commit_s && fault_s;
            if (commit_s) begin
                rf_waddr_q <= c_rd_s;
                rf_wdata_q <= result_s;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign load_fault = load_fault_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    // Every commit retires, including faulted and discarded writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= 64'd0;
        end else if (commit_s) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit (32-bit instance plus a 64-bit instance for doubleword cases).
module tb_wb_commit_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result, in_pc_plus4, in_csr_data;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_we, load_fault, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] retire_count;

    logic        w_valid, w_ready, w_rw;
    logic [4:0]  w_rd;
    logic [1:0]  w_sel;
    logic [2:0]  w_type;
    logic [2:0]  w_off;
    logic [63:0] w_alu, w_pc4, w_csr, w_rsp_data;
    logic        w_rsp_valid;
    logic        w_we, w_fault, w_busy;
    logic [4:0]  w_waddr;
    logic [63:0] w_wdata;
    logic [63:0] w_retire_count;

    wb_commit_unit #(.XLEN(32), .REG_ADDR_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_csr_data(in_csr_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_fault(load_fault), .busy(busy)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    wb_commit_unit #(.XLEN(64), .REG_ADDR_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready),
        .in_reg_write(w_rw), .in_rd(w_rd), .in_wb_sel(w_sel),
        .in_load_type(w_type), .in_addr_lo(w_off),
        .in_alu_result(w_alu), .in_pc_plus4(w_pc4), .in_csr_data(w_csr),
        .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
        .rf_we(w_we), .rf_waddr(w_waddr), .rf_wdata(w_wdata),
        .load_fault(w_fault), .busy(w_busy)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(w_retire_count)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fault;
        logic        chk_data;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        fault;
    } exp64_t;

    exp_t   sb_q[$];
    exp64_t sb64_q[$];
    exp_t   e;
    exp64_t e64;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint unsigned exp_retire = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] addr, input logic [31:0] data,
                        input logic fault, input logic chk);
        exp_t x;
        x.we = we; x.addr = addr; x.data = data; x.fault = fault; x.chk_data = chk;
        sb_q.push_back(x);
        exp_retire++;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                         input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                         input logic rspv, input logic [31:0] rsp);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd         = rd;
        in_reg_write  = rw;
        in_load_type  = lt;
        in_addr_lo    = off;
        in_alu_result = alu;
        in_pc_plus4   = alu + 32'h0000_0100;
        in_csr_data   = alu + 32'h0000_0200;
        mem_rsp_valid = rspv;
        mem_rsp_data  = rsp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_rd = 5'd0; in_wb_sel = 2'd0;
        in_load_type = 3'd0; in_addr_lo = 2'd0; in_alu_result = 32'd0;
        in_pc_plus4 = 32'd0; in_csr_data = 32'd0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        w_valid = 1'b0; w_rw = 1'b0; w_rd = 5'd0; w_sel = 2'd0; w_type = 3'd0; w_off = 3'd0;
        w_alu = 64'd0; w_pc4 = 64'd0; w_csr = 64'd0; w_rsp_valid = 1'b0; w_rsp_data = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, load_fault} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h fault=%b, want all zero",
                     rf_we, rf_waddr, rf_wdata, load_fault);
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b ready=%b, want busy=0 ready=1", busy, in_ready);
        end
        n_checks++;
        if ({w_we, w_waddr, w_wdata, w_fault, w_busy} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_rf64: got we=%b data=%h busy=%b, want zero", w_we, w_wdata, w_busy);
        end
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_retire: got %0d, want 0", retire_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive(2'd0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h0000_1234, 1'b1, 32'hFFFF_FFFF);
        push(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0; mem_rsp_valid = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || load_fault !== e.fault) begin
            n_fail++;
            $display("FAIL alu_commit: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                     rf_we, rf_waddr, rf_wdata, load_fault, e.we, e.addr, e.data, e.fault);
        end
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== exp_retire) begin
            n_fail++;
            $display("FAIL alu_retire: got %0d, want %0d", retire_count, exp_retire);
        end
`endif
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse: got rf_we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  lt  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [1:0]  off [6] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0};
        logic [31:0] dat [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8000_0000,
                                 32'h1234_F00D, 32'h7F00_0000, 32'hCAFE_BABE};
        logic [31:0] exv [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000,
                                 32'h0000_F00D, 32'h0000_007F, 32'hCAFE_BABE};
        for (int i = 0; i < 6; i++) begin
            drive(2'd1, 5'(10 + i), 1'b1, lt[i], off[i], 32'h0000_0055, 1'b1, dat[i]);
            push(1'b1, 5'(10 + i), exv[i], 1'b0, 1'b1);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || load_fault !== e.fault) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                         i, rf_we, rf_waddr, rf_wdata, load_fault, e.we, e.addr, e.data, e.fault);
            end
        end
        in_valid = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    task automatic test_wait_mem();
        drive(2'd1, 5'd9, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(2'd0, 5'd3, 1'b1, 3'b111, 2'd1, 32'h0000_5555, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_busy[%0d]: got ready=%b busy=%b we=%b, want 0 1 0", i, in_ready, busy, rf_we);
            end
            if (i < 2) tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        push(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0; mem_rsp_valid = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || load_fault !== e.fault) begin
            n_fail++;
            $display("FAIL wait_commit: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                     rf_we, rf_waddr, rf_wdata, load_fault, e.we, e.addr, e.data, e.fault);
        end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_release: got ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd9) begin
            n_fail++;
            $display("FAIL wait_no_stray: got we=%b addr=%0d, want we=0 addr=9", rf_we, rf_waddr);
        end
    endtask

    task automatic test_fault();
        logic [1:0]  sel [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        logic [4:0]  rd  [6] = '{5'd7, 5'd8, 5'd4, 5'd6, 5'd0, 5'd6};
        logic        rw  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  lt  [6] = '{3'b001, 3'b010, 3'b111, 3'b011, 3'b000, 3'b000};
        logic [1:0]  off [6] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        logic        flt [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] alu [6] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0000_ABCD, 32'h0000_0077};
        for (int i = 0; i < 6; i++) begin
            drive(sel[i], rd[i], rw[i], lt[i], off[i], alu[i], 1'b1, 32'h8081_8283);
            push(1'b0, rd[i], alu[i], flt[i], !flt[i]);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (rf_we !== e.we || rf_waddr !== e.addr || load_fault !== e.fault ||
                (e.chk_data && rf_wdata !== e.data)) begin
                n_fail++;
                $display("FAIL fault[%0d]: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                         i, rf_we, rf_waddr, rf_wdata, load_fault, e.we, e.addr, e.data, e.fault);
            end
        end
        in_valid = 1'b0; mem_rsp_valid = 1'b0;
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== exp_retire) begin
            n_fail++;
            $display("FAIL fault_retire: got %0d, want %0d", retire_count, exp_retire);
        end
`endif
        tick();
        n_checks++;
        if (load_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_pulse: got load_fault=%b, want 0", load_fault);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exv [3] = '{32'h0000_00A1, 32'h0000_01A2, 32'h0000_02A3};
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 2'd0 : 2'(i + 1), 5'(i + 1), 1'b1, 3'd0, 2'd0, 32'h0000_00A1 + 32'(i), 1'b0, 32'h0);
            push(1'b1, 5'(i + 1), exv[i], 1'b0, 1'b1);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || load_fault !== e.fault) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                         i, rf_we, rf_waddr, rf_wdata, load_fault, e.we, e.addr, e.data, e.fault);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_wait();
        drive(2'd1, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_enter: got busy=%b, want 1", busy);
        end
        #2 rst_n = 1'b0;
        exp_retire = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_async: got busy=%b ready=%b we=%b, want 0 1 0", busy, in_ready, rf_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, busy} !== 39'd0) begin
            n_fail++;
            $display("FAIL rstw_discard: got we=%b addr=%0d data=%h busy=%b, want all zero",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== 64'd0) begin
            n_fail++;
            $display("FAIL rstw_retire: got %0d, want 0", retire_count);
        end
`endif
    endtask

    task automatic test_xlen64();
        logic [2:0]  lt  [4] = '{3'b110, 3'b010, 3'b011, 3'b110};
        logic [2:0]  off [4] = '{3'd4, 3'd4, 3'd0, 3'd2};
        logic [63:0] exv [4] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001,
                                 64'h8000_0001_1234_5678, 64'h0};
        logic        flt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp64_t x;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_sel = 2'd1; w_rw = 1'b1; w_rd = 5'(20 + i);
            w_type = lt[i]; w_off = off[i]; w_rsp_valid = 1'b1;
            w_rsp_data = 64'h8000_0001_1234_5678;
            x.we = !flt[i]; x.addr = 5'(20 + i); x.data = exv[i]; x.fault = flt[i];
            sb64_q.push_back(x);
            tick();
            e64 = sb64_q.pop_front();
            n_checks++;
            if (w_we !== e64.we || w_waddr !== e64.addr || w_fault !== e64.fault ||
                (!e64.fault && w_wdata !== e64.data)) begin
                n_fail++;
                $display("FAIL xlen64[%0d]: got we=%b addr=%0d data=%h fault=%b, want we=%b addr=%0d data=%h fault=%b",
                         i, w_we, w_waddr, w_wdata, w_fault, e64.we, e64.addr, e64.data, e64.fault);
            end
        end
        w_valid = 1'b0; w_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_wait_mem();
        test_fault();
        test_back_to_back();
        test_reset_wait();
        test_xlen64();
        $display("Commits modelled since last reset: %0d", exp_retire);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
